vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares one single-port, synchronous-read video RAM between two requesters: the VGA scanout fetch path and the CPU data-bus slave port.
- Sits inside openmips_min_sopc, between the bus decoder and the framebuffer RAM that feeds the oRed/oGreen/oBlue/oHs/oVs display pipeline.
- Display has fixed priority. A starvation limit guarantees CPU progress.

Parameters:
- ADDR_W, 17, word address width of the video RAM.
- DATA_W, 32, RAM word width; must be a multiple of 8.
- CPU_MAX_WAIT, 4, maximum consecutive cycles an eligible CPU request may lose to the display; legal range is 1 or more.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- disp_req  in  1  display wants one word; level, held while more words are needed
- disp_addr  in  ADDR_W  display word address
- disp_gnt  out  1  display access issued this cycle; requester advances disp_addr on the edge
- disp_rvalid  out  1  disp_rdata valid (one cycle after disp_gnt)
- disp_rdata  out  DATA_W  display read data
- cpu_req  in  1  CPU transaction request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_sel  in  DATA_W/8  byte enables for writes
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle transaction completion
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack on reads
- mem_en  out  1  RAM access strobe
- mem_we  out  DATA_W/8  RAM byte write enables
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en

Behaviour:
- Timing style:
  - mem_*, disp_gnt: combinational from current inputs and state.
  - disp_rvalid, cpu_ack, state, wait counter: registered.
  - disp_rdata, cpu_rdata: pass through mem_rdata.
- States:
  - READY: CPU is eligible.
  - CPU_ACK: CPU access issued last cycle; CPU not eligible this cycle.
- CPU eligibility: cpu_req=1 and state=READY.
- Per-cycle decision, at most one access:
  - Reset wins. While rst=1, no grant: mem_en=0, mem_we=0, disp_gnt=0.
  - CPU wins if it is eligible and either disp_req=0 or wait_cnt==CPU_MAX_WAIT.
  - Otherwise the display wins if disp_req=1.
  - Otherwise idle: mem_en=0, mem_we=0.
- Display grant: mem_en=1, mem_we=0, mem_addr=disp_addr, disp_gnt=1. Next cycle disp_rvalid=1.
- CPU grant:
  - mem_en=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - mem_we = cpu_sel if cpu_we=1, else 0.
  - Next cycle: state=CPU_ACK, cpu_ack=1; for reads, cpu_rdata=mem_rdata.
- CPU_ACK always returns to READY after one cycle. The display may be granted during CPU_ACK.
- CPU throughput is at most 1 access per 2 cycles. A request held across cpu_ack is treated as a new transaction, issued no earlier than 2 cycles after the previous issue.
- wait_cnt, width $clog2(CPU_MAX_WAIT+1):
  - Increments when the CPU is eligible and the display is granted.
  - Clears on CPU grant or when cpu_req=0.
  - Never exceeds CPU_MAX_WAIT.
- Data-bus defaults: mem_addr and mem_wdata are don't-care when mem_en=0; drive them from cpu_* (no X).
- Reset values: state=READY, wait_cnt=0, cpu_ack=0, disp_rvalid=0.
- Reset mid-operation: an issued but unacked CPU access produces no ack, and an issued display read produces no rvalid. Any RAM write already issued stands.
- The display is never stalled more than 1 cycle in any 2 consecutive cycles while both sides request continuously.

Decomposition:
- Shared header vram_defs.vh:
  - `VRAM_ADDR_W, `VRAM_DATA_W defaults.
  - State encodings READY=1'b0, CPU_ACK=1'b1.
- No sub-module needed; the starvation counter stays inline.

Test Plan:
- Reset: rst=1 with disp_req=cpu_req=1 for 3 cycles -> mem_en=0, disp_gnt=0, cpu_ack=0, disp_rvalid=0 every cycle.
- CPU read only: cpu_addr=0x10, RAM word 0x10=0xDEADBEEF -> mem_en=1 and mem_we=0 at t; cpu_ack=1 and cpu_rdata=0xDEADBEEF at t+1; no mem_en at t+1.
- Display burst only: disp_req held, addr 0..7 advancing on gnt -> disp_gnt on 8 consecutive cycles, disp_rvalid 1 cycle delayed, data matches RAM words 0..7.
- Contention (CPU_MAX_WAIT=4): continuous disp_req; CPU write addr 0x20, data 0xA5A5A5A5, sel=4'b0011 raised at t0 ->
  - display granted t0..t3;
  - CPU issued t4 with mem_we=4'b0011;
  - cpu_ack at t5, display granted at t5;
  - readback of 0x20 shows only the low 2 bytes changed.
- Back-to-back CPU: cpu_req held through ack with new addr at t+1, display idle -> second issue at t+2, ack at t+3.
- Reset mid-transaction: CPU read issued at t, rst=1 at t+1 -> cpu_ack=0 at t+1; after rst release a fresh CPU read completes normally in 2 cycles.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter: default bus widths and the
// arbiter state encoding.
package vram_arbiter_pkg;

    localparam int VRAM_ADDR_W = 17;
    localparam int VRAM_DATA_W = 32;

    // READY   : CPU may be issued this cycle
    // CPU_ACK : CPU access issued last cycle, ack is out, CPU not eligible
    typedef enum logic {
        READY   = 1'b0,
        CPU_ACK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: shares one single-port synchronous-read RAM between the
// display scanout fetch (fixed priority) and the CPU slave port. A counter
// of consecutive CPU losses forces a CPU slot once it reaches CPU_MAX_WAIT.
//
// state   | meaning
// READY   | CPU request is eligible for issue this cycle
// CPU_ACK | CPU access issued last cycle; ack asserted, CPU not eligible
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                disp_req,
    input  logic [ADDR_W-1:0]   disp_addr,
    output logic                disp_gnt,
    output logic                disp_rvalid,
    output logic [DATA_W-1:0]   disp_rdata,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [DATA_W/8-1:0] cpu_sel,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic                cpu_ack,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int SEL_W  = DATA_W / 8;
    localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ack_q;
    logic              rvalid_q;
    logic              cpu_elig;
    logic              cpu_win;
    logic              disp_win;

    // Per-cycle winner selection and RAM port drive
    always_comb begin
        cpu_elig  = cpu_req && (state == READY);
        cpu_win   = 1'b0;
        disp_win  = 1'b0;
        if (!rst) begin
            if (cpu_elig && (!disp_req || wait_cnt == WAIT_MAX)) begin
                cpu_win = 1'b1;
            end else if (disp_req) begin
                disp_win = 1'b1;
            end
        end
        mem_en    = cpu_win || disp_win;
        mem_we    = (cpu_win && cpu_we) ? cpu_sel : {SEL_W{1'b0}};
        mem_addr  = disp_win ? disp_addr : cpu_addr;
        mem_wdata = cpu_wdata;
        disp_gnt  = disp_win;
    end

    // State, starvation counter and completion strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= READY;
            wait_cnt <= '0;
            ack_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            ack_q    <= cpu_win;
            rvalid_q <= disp_win;
            state    <= cpu_win ? CPU_ACK : READY;
            if (cpu_win || !cpu_req) begin
                wait_cnt <= '0;
            end else if (cpu_elig && disp_win && wait_cnt < WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Reset in the cycle after an issue swallows the pending ack/rvalid,
    // so the strobes are qualified with rst as well as being registered.
    assign cpu_ack     = ack_q && !rst;
    assign disp_rvalid = rvalid_q && !rst;
    assign cpu_rdata   = mem_rdata;
    assign disp_rdata  = mem_rdata;

endmodule
